regfile_alu_datapath: RTL

//  Execution datapath directly downstream of the control FSMs (e.g. the fibonacci sequencer).

---
 rtl/regfile_alu_datapath_if.sv | 26 ++
 rtl/regfile_alu_datapath.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/regfile_alu_datapath_if.sv
// Control-word and status bundle between the sequencing FSM and the datapath.
// master = FSM side (drives the control word), slave = datapath side.
interface regfile_alu_datapath_if #(
  parameter int WIDTH = 16
);
  logic [15:0]      wEnable;
  logic [WIDTH-1:0] Imm_in;
  logic [7:0]       opcode;
  logic [3:0]       Rdest_sel;
  logic [3:0]       Rsrc_sel;
  logic             Imm_sel;
  logic [4:0]       Flags_out;
  logic [4:0]       Flags_q;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] result_out;

  modport master (
    output wEnable, Imm_in, opcode, Rdest_sel, Rsrc_sel, Imm_sel,
    input  Flags_out, Flags_q, alu_out, result_out
  );

  modport slave (
    input  wEnable, Imm_in, opcode, Rdest_sel, Rsrc_sel, Imm_sel,
    output Flags_out, Flags_q, alu_out, result_out
  );
endinterface

// File: rtl/regfile_alu_datapath.sv
// 16-entry register file plus single-cycle ALU executing one control word per clock.
// Latency: alu_out/Flags_out combinational; register writes and Flags_q visible 1 clk later.
// Backpressure: none; the upstream FSM owns all sequencing and the datapath always accepts.
module regfile_alu_datapath #(
  parameter int WIDTH   = 16,
  parameter int OUT_REG = 5
) (
  input logic             clk,
  input logic             reset,
  regfile_alu_datapath_if.slave dp
);

  localparam int NREGS = 16;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_AND   = 8'h01;
  localparam logic [7:0] OP_OR    = 8'h02;
  localparam logic [7:0] OP_XOR   = 8'h03;
  localparam logic [7:0] OP_ADD   = 8'h05;
  localparam logic [7:0] OP_ADDU  = 8'h06;
  localparam logic [7:0] OP_ADDUI = 8'h60;
  localparam logic [7:0] OP_SUB   = 8'h09;
  localparam logic [7:0] OP_CMP   = 8'h0B;
  localparam logic [7:0] OP_MOV   = 8'h0D;
  localparam logic [7:0] OP_LSH   = 8'h84;

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] alu_res;
  logic [4:0]       flags_nxt;
  logic [4:0]       flags_q;
  logic             wr_ok;
  logic             flag_upd;

  // Flag layout {L,C,F,Z,N}; logic ops only report Z and N.
  function automatic logic [4:0] zn_flags(input logic [WIDTH-1:0] r);
    return {3'b000, (r == '0), r[WIDTH-1]};
  endfunction

  assign op_a   = regs[dp.Rdest_sel];
  assign op_b   = dp.Imm_sel ? regs[dp.Rsrc_sel] : dp.Imm_in;
  assign sum_w  = {1'b0, op_a} + {1'b0, op_b};
  assign diff_w = {1'b0, op_a} - {1'b0, op_b};

  // Signed overflow: add when like-signed operands give an unlike-signed result,
  // subtract when unlike-signed operands flip the sign of A.
  assign add_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum_w[WIDTH-1]  != op_a[WIDTH-1]);
  assign sub_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff_w[WIDTH-1] != op_a[WIDTH-1]);

  always_comb begin
    alu_res   = '0;
    flags_nxt = flags_q;
    wr_ok     = 1'b0;
    flag_upd  = 1'b0;
    case (dp.opcode)
      OP_AND: begin
        alu_res   = op_a & op_b;
        flags_nxt = zn_flags(alu_res);
        wr_ok     = 1'b1;
        flag_upd  = 1'b1;
      end
      OP_OR: begin
        alu_res   = op_a | op_b;
        flags_nxt = zn_flags(alu_res);
        wr_ok     = 1'b1;
        flag_upd  = 1'b1;
      end
      OP_XOR: begin
        alu_res   = op_a ^ op_b;
        flags_nxt = zn_flags(alu_res);
        wr_ok     = 1'b1;
        flag_upd  = 1'b1;
      end
      OP_ADD, OP_ADDU, OP_ADDUI: begin
        alu_res   = sum_w[WIDTH-1:0];
        flags_nxt = {1'b0, sum_w[WIDTH], add_ovf, (alu_res == '0), alu_res[WIDTH-1]};
        wr_ok     = 1'b1;
        flag_upd  = 1'b1;
      end
      OP_SUB: begin
        // diff_w[WIDTH] is the borrow, i.e. A < B unsigned.
        alu_res   = diff_w[WIDTH-1:0];
        flags_nxt = {1'b0, diff_w[WIDTH], sub_ovf, (alu_res == '0), alu_res[WIDTH-1]};
        wr_ok     = 1'b1;
        flag_upd  = 1'b1;
      end
      OP_CMP: begin
        flags_nxt = {diff_w[WIDTH], 2'b00, (op_a == op_b), ($signed(op_a) < $signed(op_b))};
        flag_upd  = 1'b1;
      end
      OP_MOV: begin
        alu_res   = op_b;
        flags_nxt = zn_flags(alu_res);
        wr_ok     = 1'b1;
        flag_upd  = 1'b1;
      end
      OP_LSH: begin
        alu_res   = op_a << op_b[3:0];
        flags_nxt = zn_flags(alu_res);
        wr_ok     = 1'b1;
        flag_upd  = 1'b1;
      end
      default: begin
        // NOP and undefined opcodes: result 0, flags held, no writes.
        alu_res = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_ok && dp.wEnable[i]) begin
          regs[i] <= alu_res;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= '0;
    end else if (flag_upd) begin
      flags_q <= flags_nxt;
    end
  end

  assign dp.alu_out    = alu_res;
  assign dp.Flags_out  = flags_nxt;
  assign dp.Flags_q    = flags_q;
  assign dp.result_out = regs[OUT_REG];

endmodule
